// File: rtl/skew_delay_bank_pkg.sv
// Shared helpers for the skew delay bank: per-lane depth, deepest lane
// depth, and the width of the fill counter that tracks the deepest lane.
package skew_delay_pkg;

  // Depth of lane c: lane 0 has base_depth, each later lane adds skew.
  function automatic int lane_depth(input int c, input int base_depth, input int skew);
    return base_depth + c * skew;
  endfunction

  // Depth of the last (deepest) lane.
  function automatic int max_depth(input int channels, input int base_depth, input int skew);
    return base_depth + (channels - 1) * skew;
  endfunction

  // Counter width able to hold values 0..max_d inclusive.
  function automatic int cnt_width(input int max_d);
    return (max_d < 1) ? 1 : $clog2(max_d + 1);
  endfunction

endpackage

// File: rtl/skew_delay_bank_if.sv
// Lane bus of the delay bank.
// The master drives en, clr, d and d_valid. The slave returns q, q_valid and
// primed. There is no backpressure: en is a shift strobe common to every lane,
// and q/q_valid always present the oldest entry of each lane.
interface skew_delay_bank_if #(
  parameter int CHANNELS = 8,
  parameter int BITS     = 64
);
  logic                     en;
  logic                     clr;
  logic [CHANNELS*BITS-1:0] d;
  logic [CHANNELS-1:0]      d_valid;
  logic [CHANNELS*BITS-1:0] q;
  logic [CHANNELS-1:0]      q_valid;
  logic                     primed;

  modport master (
    output en, clr, d, d_valid,
    input  q, q_valid, primed
  );

  modport slave (
    input  en, clr, d, d_valid,
    output q, q_valid, primed
  );
endinterface

// File: rtl/skew_delay_bank_delay_line.sv
// One lane of the bank: a DEPTH-stage shift register. The valid bit is folded
// into the word as its MSB, so it travels in lockstep with the data.
// q is the last stage, a pure register output.
module delay_line #(
  parameter int DEPTH = 8,
  parameter int BITS  = 65
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            en,
  input  logic            clr,
  input  logic [BITS-1:0] d,
  output logic [BITS-1:0] q
);

  if (DEPTH < 1) begin : g_bad_depth
    $fatal(1, "delay_line: DEPTH must be at least 1");
  end

  logic [BITS-1:0] stages [DEPTH];

  // Shift chain: clear has priority over shift; disabled edges hold.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) stages[i] <= '0;
    end else if (clr) begin
      for (int i = 0; i < DEPTH; i++) stages[i] <= '0;
    end else if (en) begin
      stages[0] <= d;
      for (int i = 1; i < DEPTH; i++) stages[i] <= stages[i-1];
    end
  end

  assign q = stages[DEPTH-1];

endmodule

// File: rtl/skew_delay_bank.sv
// Multi-lane delay bank. Lane c delays its word by DEPTH + c*SKEW enabled
// edges. With SKEW > 0 this produces the diagonal wavefront that feeds the
// edges of a systolic array. A saturating fill counter raises primed once the
// deepest lane has been completely filled since reset or clear.
module skew_delay_bank
  import skew_delay_pkg::*;
#(
  parameter int CHANNELS = 8,
  parameter int BITS     = 64,
  parameter int DEPTH    = 8,
  parameter int SKEW     = 0
) (
  input  logic            clk,
  input  logic            rst,
  skew_delay_bank_if.slave bus
);

  localparam int MAX_D = max_depth(CHANNELS, DEPTH, SKEW);
  localparam int CW    = cnt_width(MAX_D);
  localparam logic [CW-1:0] MAX_CNT = CW'(MAX_D);

  if (CHANNELS < 1 || BITS < 1 || DEPTH < 1) begin : g_bad_params
    $fatal(1, "skew_delay_bank: CHANNELS, BITS and DEPTH must all be at least 1");
  end

  logic [CHANNELS*BITS-1:0] q_all;
  logic [CHANNELS-1:0]      q_valid_all;
  logic [CW-1:0]            fill_cnt;
  logic [CW-1:0]            fill_cnt_next;
  logic                     primed_r;

  for (genvar c = 0; c < CHANNELS; c++) begin : g_lane
    logic [BITS:0] lane_q;

    delay_line #(
      .DEPTH (lane_depth(c, DEPTH, SKEW)),
      .BITS  (BITS + 1)
    ) u_line (
      .clk (clk),
      .rst (rst),
      .en  (bus.en),
      .clr (bus.clr),
      .d   ({bus.d_valid[c], bus.d[c*BITS +: BITS]}),
      .q   (lane_q)
    );

    assign q_all[c*BITS +: BITS] = lane_q[BITS-1:0];
    assign q_valid_all[c]        = lane_q[BITS];
  end

  // Saturating increment: stops at the deepest lane's depth, never wraps.
  always_comb begin
    fill_cnt_next = fill_cnt;
    if (fill_cnt != MAX_CNT) fill_cnt_next = fill_cnt + CW'(1);
  end

  // Fill counter and sticky primed flag; primed is set on the same edge the
  // counter reaches the maximum, so it rises after MAX_D enabled edges.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      fill_cnt <= '0;
      primed_r <= 1'b0;
    end else if (bus.clr) begin
      fill_cnt <= '0;
      primed_r <= 1'b0;
    end else if (bus.en) begin
      fill_cnt <= fill_cnt_next;
      primed_r <= primed_r | (fill_cnt_next == MAX_CNT);
    end
  end

  assign bus.q       = q_all;
  assign bus.q_valid = q_valid_all;
  assign bus.primed  = primed_r;

endmodule

// File: tb/tb_skew_delay_bank.sv
// Directed bench for skew_delay_bank: a skewed instance (depths 2,3,4,5)
// driven from a vector table, plus hand-written sequences for primed
// saturation, asynchronous reset mid-cycle, and a uniform depth-1 instance.
module tb_skew_delay_bank;

  localparam int CH = 4;
  localparam int BW = 8;

  logic clk;
  logic rst;

  int checks;
  int failures;

  skew_delay_bank_if #(.CHANNELS(CH), .BITS(BW)) bus_a ();
  skew_delay_bank_if #(.CHANNELS(CH), .BITS(BW)) bus_u ();

  skew_delay_bank #(.CHANNELS(CH), .BITS(BW), .DEPTH(2), .SKEW(1)) dut_skew (
    .clk (clk),
    .rst (rst),
    .bus (bus_a)
  );

  skew_delay_bank #(.CHANNELS(CH), .BITS(BW), .DEPTH(1), .SKEW(0)) dut_uni (
    .clk (clk),
    .rst (rst),
    .bus (bus_u)
  );

  // Clock
  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        en;
    logic        clr;
    logic [31:0] d;
    logic [3:0]  dv;
    logic [31:0] exp_q;
    logic [3:0]  exp_qv;
    logic        exp_p;
  } vec_t;

  vec_t tab[$];

  function automatic vec_t mk(input logic en, input logic clr, input logic [31:0] d,
                              input logic [3:0] dv, input logic [31:0] eq,
                              input logic [3:0] eqv, input logic ep);
    vec_t v;
    v.en = en; v.clr = clr; v.d = d; v.dv = dv;
    v.exp_q = eq; v.exp_qv = eqv; v.exp_p = ep;
    return v;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp_v);
    checks++;
    if (act !== exp_v) begin
      failures++;
      $display("FAIL %s: got %h expected %h", nm, act, exp_v);
    end
  endtask

  // Drive one vector onto the skewed instance, clock once, then check.
  task automatic apply_vec(input int idx, input vec_t v);
    bus_a.en      = v.en;
    bus_a.clr     = v.clr;
    bus_a.d       = v.d;
    bus_a.d_valid = v.dv;
    @(posedge clk);
    #1;
    chk($sformatf("vec%0d_q", idx), bus_a.q, v.exp_q);
    chk($sformatf("vec%0d_qv", idx), {28'd0, bus_a.q_valid}, {28'd0, v.exp_qv});
    chk($sformatf("vec%0d_primed", idx), {31'd0, bus_a.primed}, {31'd0, v.exp_p});
  endtask

  logic [31:0] exp_uq;
  logic [3:0]  exp_uqv;

  initial begin
    checks   = 0;
    failures = 0;
    rst = 1'b1;
    bus_a.en = 1'b0; bus_a.clr = 1'b0; bus_a.d = '0; bus_a.d_valid = '0;
    bus_u.en = 1'b0; bus_u.clr = 1'b0; bus_u.d = '0; bus_u.d_valid = '0;

    // Reset values
    #1;
    chk("rst_q", bus_a.q, 32'h0);
    chk("rst_qv", {28'd0, bus_a.q_valid}, 32'h0);
    chk("rst_primed", {31'd0, bus_a.primed}, 32'h0);
    chk("rst_uni_primed", {31'd0, bus_u.primed}, 32'h0);
    #20;
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk);
    #1;

    // Skew latency: lane c arrives after 2+c enabled edges.
    tab.push_back(mk(1, 0, 32'h13121110, 4'hF, 32'h00000000, 4'h0, 0));
    tab.push_back(mk(1, 0, 32'h00000000, 4'h0, 32'h00000010, 4'h1, 0));
    tab.push_back(mk(1, 0, 32'h00000000, 4'h0, 32'h00001100, 4'h2, 0));
    tab.push_back(mk(1, 0, 32'h00000000, 4'h0, 32'h00120000, 4'h4, 0));
    tab.push_back(mk(1, 0, 32'h00000000, 4'h0, 32'h13000000, 4'h8, 1));
    tab.push_back(mk(1, 0, 32'h00000000, 4'h0, 32'h00000000, 4'h0, 1));
    // Clear priority with data in flight; 0x55 and 0xFF must never surface.
    tab.push_back(mk(1, 0, 32'h55555555, 4'hF, 32'h00000000, 4'h0, 1));
    tab.push_back(mk(1, 1, 32'hFFFFFFFF, 4'hF, 32'h00000000, 4'h0, 0));
    tab.push_back(mk(1, 0, 32'h00000000, 4'h0, 32'h00000000, 4'h0, 0));
    tab.push_back(mk(1, 0, 32'h00000000, 4'h0, 32'h00000000, 4'h0, 0));
    tab.push_back(mk(1, 0, 32'h00000000, 4'h0, 32'h00000000, 4'h0, 0));
    tab.push_back(mk(1, 0, 32'h00000000, 4'h0, 32'h00000000, 4'h0, 0));
    tab.push_back(mk(1, 0, 32'h00000000, 4'h0, 32'h00000000, 4'h0, 1));
    // Enable gaps: arrival counted in enabled edges only, outputs hold.
    tab.push_back(mk(1, 0, 32'h23222120, 4'hF, 32'h00000000, 4'h0, 1));
    for (int i = 0; i < 3; i++)
      tab.push_back(mk(0, 0, 32'hAAAAAAAA, 4'hF, 32'h00000000, 4'h0, 1));
    tab.push_back(mk(1, 0, 32'h00000000, 4'h0, 32'h00000020, 4'h1, 1));
    for (int i = 0; i < 3; i++)
      tab.push_back(mk(0, 0, 32'hAAAAAAAA, 4'hF, 32'h00000020, 4'h1, 1));
    tab.push_back(mk(1, 0, 32'h00000000, 4'h0, 32'h00002100, 4'h2, 1));
    tab.push_back(mk(1, 0, 32'h00000000, 4'h0, 32'h00220000, 4'h4, 1));
    for (int i = 0; i < 3; i++)
      tab.push_back(mk(0, 0, 32'hAAAAAAAA, 4'hF, 32'h00220000, 4'h4, 1));
    tab.push_back(mk(1, 0, 32'h00000000, 4'h0, 32'h23000000, 4'h8, 1));
    tab.push_back(mk(1, 0, 32'h00000000, 4'h0, 32'h00000000, 4'h0, 1));

    foreach (tab[i]) apply_vec(i, tab[i]);

    // Primed saturation: 20 further enabled edges, primed stays high.
    bus_a.en = 1'b1; bus_a.clr = 1'b0; bus_a.d = '0; bus_a.d_valid = '0;
    for (int i = 0; i < 20; i++) begin
      @(posedge clk);
      #1;
      chk($sformatf("sat%0d_primed", i), {31'd0, bus_a.primed}, 32'h1);
    end

    // Fill lanes with valid words, then reset asynchronously mid-cycle.
    bus_a.d = 32'h77777777; bus_a.d_valid = 4'hF;
    for (int i = 0; i < 5; i++) begin
      @(posedge clk);
      #1;
    end
    chk("full_q", bus_a.q, 32'h77777777);
    chk("full_qv", {28'd0, bus_a.q_valid}, 32'hF);
    #3;
    rst = 1'b1;
    #1;
    chk("async_rst_q", bus_a.q, 32'h0);
    chk("async_rst_qv", {28'd0, bus_a.q_valid}, 32'h0);
    chk("async_rst_primed", {31'd0, bus_a.primed}, 32'h0);
    // Edges while rst is high have no effect.
    @(posedge clk);
    #1;
    chk("rst_hold_q", bus_a.q, 32'h0);
    chk("rst_hold_primed", {31'd0, bus_a.primed}, 32'h0);
    rst = 1'b0;
    bus_a.en = 1'b0;
    bus_a.d = '0; bus_a.d_valid = '0;
    // No partial state survives: lane 0 emits only the new word.
    bus_a.en = 1'b1; bus_a.d = 32'h00000042; bus_a.d_valid = 4'h1;
    @(posedge clk);
    #1;
    bus_a.d = '0; bus_a.d_valid = '0;
    @(posedge clk);
    #1;
    chk("post_rst_q", bus_a.q, 32'h00000042);
    chk("post_rst_qv", {28'd0, bus_a.q_valid}, 32'h1);
    chk("post_rst_primed", {31'd0, bus_a.primed}, 32'h0);
    bus_a.en = 1'b0;

    // Uniform depth-1 instance: q equals d of the previous enabled edge.
    chk("uni_init_primed", {31'd0, bus_u.primed}, 32'h0);
    exp_uq  = '0;
    exp_uqv = '0;
    for (int k = 1; k <= 8; k++) begin
      logic [7:0] kb;
      kb = 8'(k);
      bus_u.en      = (k != 4);
      bus_u.d       = {kb + 8'h30, kb + 8'h20, kb + 8'h10, kb};
      bus_u.d_valid = kb[3:0];
      if (bus_u.en) begin
        exp_uq  = bus_u.d;
        exp_uqv = bus_u.d_valid;
      end
      @(posedge clk);
      #1;
      chk($sformatf("uni%0d_q", k), bus_u.q, exp_uq);
      chk($sformatf("uni%0d_qv", k), {28'd0, bus_u.q_valid}, {28'd0, exp_uqv});
      chk($sformatf("uni%0d_primed", k), {31'd0, bus_u.primed}, 32'h1);
    end
    bus_u.en = 1'b0;

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/skew_delay_bank.md
Name: skew_delay_bank

Overview:
- Multi-channel, parametrised delay-buffer bank; successor to the single-channel shift-register delay FIFO.
- Each channel delays its lane by a fixed depth. In skew mode, depth grows by a step per channel, producing the diagonal wavefront that feeds the systolic array edges.
- Adds per-lane valid tracking, synchronous clear, and a primed indicator.

Parameters:
- CHANNELS, 8, number of independent lanes.
- BITS, 64, data width per lane.
- DEPTH, 8, depth of lane 0 (≥1).
- SKEW, 0, extra depth per lane index. Lane c depth D_c = DEPTH + c*SKEW. SKEW=0 gives uniform depth.

Ports:
- clk  input  1  rising-edge clock.
- rst  input  1  asynchronous, active-high reset.
- en  input  1  shift enable; all lanes shift together.
- clr  input  1  synchronous clear of contents, valids and fill counter.
- d  input  CHANNELS*BITS  lane c data is bits [c*BITS +: BITS].
- d_valid  input  CHANNELS  per-lane valid travelling with d.
- q  output  CHANNELS*BITS  oldest entry of each lane, same packing as d.
- q_valid  output  CHANNELS  valid bit of the entry currently on q.
- primed  output  1  high once the deepest lane has been completely filled since reset/clr.

Behaviour:
- Reset (rst=1, asynchronous): every storage entry, q, q_valid, fill counter and primed = 0 immediately, independent of clk. While rst is high, clk edges have no effect.
- Shift: on a clk rising edge with en=1 and clr=0, each lane c shifts one place. d/d_valid enter stage 0; stage D_c-1 is presented on q/q_valid.
- Hold: with en=0, all state holds.
- Latency: a word sampled on enabled edge k appears on lane c's q immediately after enabled edge k+D_c-1, i.e. visible after D_c enabled edges. Disabled cycles do not count.
- Depth 1: when D_c=1, the lane is a single register and q follows d one enabled edge later.
- q is a register output with no combinational path from d.
- Clear: on a clk edge with clr=1, all entries, q_valid, counter and primed go to 0. clr has priority over en; d is discarded on that edge.
- Fill counter: width $clog2(MAX_DEPTH+1), where MAX_DEPTH = DEPTH + (CHANNELS-1)*SKEW.
  - Increments on each enabled, non-clear edge and saturates at MAX_DEPTH; no wrap.
  - primed = (counter == MAX_DEPTH), registered.
  - Once set, primed stays high until rst or clr.
- Valid tracking:
  - q_valid reflects d_valid shifted with the data.
  - Invalid words still shift and occupy slots; no compaction or bubble collapse.
- Reset mid-operation: all in-flight data is lost; no partial state is retained.
- Width rules: all lanes are identical in width and there is no arithmetic on data. Lane indexing is 0..CHANNELS-1 LSB-first.
- Elaboration check: DEPTH<1, CHANNELS<1 or BITS<1 is a fatal elaboration error.

Decomposition:
- Package skew_delay_pkg holds:
  - function lane_depth(c, DEPTH, SKEW);
  - function max_depth(CHANNELS, DEPTH, SKEW);
  - localparam-style helper for counter width.
- Sub-module delay_line (parameters DEPTH, BITS+1; ports clk, rst, en, clr, d, q) implements one lane with valid folded in as the MSB.
  - Instantiated CHANNELS times via generate, with DEPTH = lane_depth(c).
- Fill counter and primed logic live in the top.

Test Plan (CHANNELS=4, BITS=8, DEPTH=2, SKEW=1, so lane depths are 2, 3, 4, 5):
- Reset: assert rst asynchronously mid-cycle with lanes full -> q=0, q_valid=0, primed=0 before the next clk edge.
- Skew latency: en=1, drive lane c with 0x10+c at cycle 0 with d_valid=1, and with 0 and d_valid=0 afterwards -> lane 0 shows 0x10 after edge 2, lane 1 shows 0x11 after edge 3, lane 2 shows 0x12 after edge 4, lane 3 shows 0x13 after edge 5. Each q_valid is high for exactly one cycle.
- Enable gaps: insert en=0 for 3 cycles between enabled edges -> outputs hold, and arrival is counted in enabled edges only. Lane 3 still needs 5 enabled edges.
- Primed: from reset, en=1 continuously -> primed rises after the 5th enabled edge. It stays high after 20 further edges (counter saturates at 5, no wrap).
- Clear priority: apply clr=1 and en=1 on the same edge with d=0xFF -> all q=0, q_valid=0, primed=0, and 0xFF never appears on any lane.
- Uniform mode: SKEW=0, DEPTH=1 instance, stream 0x01..0x08 -> each lane's q equals d delayed one enabled edge. primed rises after the 1st enabled edge.
